// File: rtl/tnn_feat_pkg.sv
// Shared constants, default threshold table and state encoding for the feature framer.
package tnn_feat_pkg;

  localparam int unsigned NFEAT = 7;
  localparam int unsigned RAW_W = 8;
  localparam int unsigned Q_W   = 2;
  localparam int unsigned NLVL  = 3;

  // Entry k is threshold t_k applied to every feature after reset.
  localparam logic [NLVL-1:0][RAW_W-1:0] THR_DEF = {8'd192, 8'd128, 8'd64};

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILL,
    S_HOLD,
    S_HOLD_FILL
  } state_e;

endpackage

// File: rtl/tnn_feature_frame_if.sv
// Raw-feature stream, threshold config port and quantized-frame output of the framer.
interface tnn_feature_frame_if #(
  parameter int unsigned NFEAT = tnn_feat_pkg::NFEAT,
  parameter int unsigned RAW_W = tnn_feat_pkg::RAW_W,
  parameter int unsigned Q_W   = tnn_feat_pkg::Q_W
) ();

  logic                   in_valid;
  logic [RAW_W-1:0]       in_data;
  logic                   in_last;
  logic                   in_ready;
  logic                   cfg_we;
  logic [2:0]             cfg_feat;
  logic [1:0]             cfg_lvl;
  logic [RAW_W-1:0]       cfg_data;
  logic                   out_valid;
  logic [NFEAT*Q_W-1:0]   out_frame;
  logic                   out_ready;
  logic                   err_pulse;

  modport master (
    output in_valid, in_data, in_last, cfg_we, cfg_feat, cfg_lvl, cfg_data, out_ready,
    input  in_ready, out_valid, out_frame, err_pulse
  );

  modport slave (
    input  in_valid, in_data, in_last, cfg_we, cfg_feat, cfg_lvl, cfg_data, out_ready,
    output in_ready, out_valid, out_frame, err_pulse
  );

endinterface

// File: rtl/tnn_feat_quant.sv
// Maps one raw feature to a 2-bit level: the number of its three thresholds it reaches.
module tnn_feat_quant
  import tnn_feat_pkg::*;
#(
  parameter int unsigned P_RAW_W = tnn_feat_pkg::RAW_W
) (
  input  logic [P_RAW_W-1:0]           i_data,
  input  logic [NLVL-1:0][P_RAW_W-1:0] i_thr,
  output logic [1:0]                   o_level
);

  logic w_ge0, w_ge1, w_ge2;

  // Thresholds are not assumed ordered, so each compare counts independently.
  assign w_ge0   = (i_data >= i_thr[0]);
  assign w_ge1   = (i_data >= i_thr[1]);
  assign w_ge2   = (i_data >= i_thr[2]);
  assign o_level = {1'b0, w_ge0} + {1'b0, w_ge1} + {1'b0, w_ge2};

endmodule

// File: rtl/tnn_feature_frame.sv
// Collects NFEAT quantized features into a frame, checks in_last framing and hands
// the frame to the classifier through a one-deep output register.
module tnn_feature_frame #(
  parameter int unsigned NFEAT = tnn_feat_pkg::NFEAT,
  parameter int unsigned RAW_W = tnn_feat_pkg::RAW_W,
  parameter int unsigned Q_W   = tnn_feat_pkg::Q_W
) (
  input logic               clk,
  input logic               rst_n,
  tnn_feature_frame_if.slave bus
);

  import tnn_feat_pkg::*;

  localparam int unsigned CNT_W = $clog2(NFEAT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NFEAT - 1);

  state_e                          r_state;
  logic [CNT_W-1:0]                r_cnt;
  logic [NFEAT-1:0][Q_W-1:0]       r_fill;
  logic [NFEAT*Q_W-1:0]            r_frame;
  logic                            r_err;
  logic [NLVL-1:0][RAW_W-1:0]      r_thr [NFEAT];

  logic                      w_full, w_last_slot, w_xfer, w_done, w_frame_err, w_out_hs, w_cfg_ok;
  logic [Q_W-1:0]            w_level;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_full_nxt;
  state_e                    w_state_nxt;
  logic [NFEAT-1:0][Q_W-1:0] w_frame_nxt;

  assign w_full      = (r_state == S_HOLD) || (r_state == S_HOLD_FILL);
  assign w_last_slot = (r_cnt == LAST_IDX);
  assign w_out_hs    = w_full && bus.out_ready;
  assign w_xfer      = bus.in_valid && bus.in_ready;
  assign w_done      = w_xfer && w_last_slot && bus.in_last;
  assign w_frame_err = w_xfer && (bus.in_last != w_last_slot);
  assign w_cfg_ok    = (32'(bus.cfg_feat) < NFEAT) && (bus.cfg_lvl != 2'd3);

  // Only a completed frame needs the output slot, so stall just that last feature.
  assign bus.in_ready  = !(w_last_slot && w_full && !bus.out_ready);
  assign bus.out_valid = w_full;
  assign bus.out_frame = r_frame;
  assign bus.err_pulse = r_err;

  tnn_feat_quant #(.P_RAW_W(RAW_W)) u_quant (
    .i_data  (bus.in_data),
    .i_thr   (r_thr[r_cnt]),
    .o_level (w_level)
  );

  always_comb begin
    w_frame_nxt            = r_fill;
    w_frame_nxt[NFEAT-1]   = w_level;
    w_cnt_nxt              = r_cnt;
    if (w_xfer) begin
      w_cnt_nxt = (w_done || w_frame_err) ? '0 : r_cnt + CNT_W'(1);
    end
    w_full_nxt = w_done || (w_full && !w_out_hs);
    if (w_full_nxt) begin
      w_state_nxt = (w_cnt_nxt != '0) ? S_HOLD_FILL : S_HOLD;
    end else begin
      w_state_nxt = (w_cnt_nxt != '0) ? S_FILL : S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
      r_fill  <= '0;
      r_frame <= '0;
      r_err   <= 1'b0;
      for (int f = 0; f < NFEAT; f++) begin
        r_thr[f] <= THR_DEF;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_frame_err;
      if (w_xfer) begin
        r_fill[r_cnt] <= w_level;
      end
      if (w_done) begin
        r_frame <= w_frame_nxt;
      end
      // Same-cycle transfers still see the old threshold value.
      if (bus.cfg_we && w_cfg_ok) begin
        r_thr[bus.cfg_feat][bus.cfg_lvl] <= bus.cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_tnn_feature_frame.sv
// Directed bench for tnn_feature_frame: framing, quantization, backpressure, config and reset.
module tb_tnn_feature_frame;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  tnn_feature_frame_if bus ();

  tnn_feature_frame dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One feature presented for one cycle; caller ensures in_ready is high.
  task automatic send(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d0, d1, d2, d3, d4, d5, d6);
    send(d0, 1'b0); send(d1, 1'b0); send(d2, 1'b0); send(d3, 1'b0);
    send(d4, 1'b0); send(d5, 1'b0); send(d6, 1'b1);
  endtask

  initial begin
    logic [13:0] exp_f;
    int          n_valid;
    int          n_stall;
    n_run = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_feat = '0; bus.cfg_lvl = '0; bus.cfg_data = '0;
    bus.out_ready = 1'b1;
    #23;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_frame", 32'(bus.out_frame), 32'd0);
    check("rst_err", 32'(bus.err_pulse), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Default thresholds across all level boundaries.
    send_frame(8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd255);
    check("basic_valid", 32'(bus.out_valid), 32'd1);
    check("basic_frame", 32'(bus.out_frame), 32'h3A50);
    step();
    check("basic_consumed", 32'(bus.out_valid), 32'd0);

    // Backpressure: second frame's last feature stalls until the first is taken.
    bus.out_ready = 1'b0;
    send_frame(8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200);
    check("bp_first_frame", 32'(bus.out_frame), 32'h3FFF);
    for (int i = 0; i < 6; i++) send(8'd0, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 8'd100; bus.in_last = 1'b1;
    #1;
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
    check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    check("bp_hold_frame", 32'(bus.out_frame), 32'h3FFF);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("bp_no_bubble", 32'(bus.out_valid), 32'd1);
    check("bp_second_frame", 32'(bus.out_frame), 32'h1000);
    step();
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Early in_last, then a clean frame, then a missing in_last.
    send(8'd10, 1'b0); send(8'd10, 1'b0); send(8'd10, 1'b0); send(8'd10, 1'b1);
    check("err_early_pulse", 32'(bus.err_pulse), 32'd1);
    check("err_early_novalid", 32'(bus.out_valid), 32'd0);
    step();
    check("err_pulse_clear", 32'(bus.err_pulse), 32'd0);
    send_frame(8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128);
    check("err_recover_frame", 32'(bus.out_frame), 32'h2333);
    check("err_recover_noerr", 32'(bus.err_pulse), 32'd0);
    step();
    for (int i = 0; i < 7; i++) send(8'd0, 1'b0);
    check("err_late_pulse", 32'(bus.err_pulse), 32'd1);
    check("err_late_novalid", 32'(bus.out_valid), 32'd0);

    // Threshold write in the same cycle as the affected feature.
    send(8'd0, 1'b0); send(8'd0, 1'b0);
    bus.cfg_we = 1'b1; bus.cfg_feat = 3'd2; bus.cfg_lvl = 2'd0; bus.cfg_data = 8'd10;
    send(8'd20, 1'b0);
    bus.cfg_we = 1'b0;
    send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b1);
    check("cfg_old_value", 32'(bus.out_frame), 32'h0000);
    send_frame(8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0);
    check("cfg_new_value", 32'(bus.out_frame), 32'h0010);

    // Reset with a held frame and a partial frame in progress.
    bus.out_ready = 1'b0;
    send_frame(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_frame", 32'(bus.out_frame), 32'd0);
    check("rst_mid_err", 32'(bus.err_pulse), 32'd0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    send_frame(8'd64, 8'd128, 8'd20, 8'd192, 8'd0, 8'd0, 8'd0);
    check("rst_thr_default", 32'(bus.out_frame), 32'h00C9);
    check("rst_err_none", 32'(bus.err_pulse), 32'd0);
    step();

    // Back-to-back frames, consumer always ready.
    n_valid = 0; n_stall = 0;
    for (int k = 0; k < 3; k++) begin
      exp_f = '0;
      for (int i = 0; i < 7; i++) begin
        logic [1:0] lvl;
        lvl = 2'((i + k) % 4);
        exp_f[2*i +: 2] = lvl;
        if (!bus.in_ready) n_stall++;
        send(8'(lvl * 64), (i == 6));
        if (bus.out_valid) n_valid++;
      end
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
      check("b2b_frame", 32'(bus.out_frame), 32'(exp_f));
    end
    check("b2b_frame_count", 32'(n_valid), 32'd3);
    check("b2b_no_stall", 32'(n_stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
